// File: rtl/min_max_detector_pkg.sv
// Shared definitions for the min/max peak detector: FSM encoding and default widths.
// No logic here; all timing lives in the importing modules.
// No flow control; constants only.
package min_max_detector_pkg;

    // Default ADC sample width and sample-memory address width.
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 10;

    // Acquisition FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : min_max_detector_pkg

// File: rtl/min_max_detector_acc.sv
// Running min/max accumulator pair for one decimation interval, with close/reload.
// Results are combinational on the closing cycle; accumulators update on the clock edge.
// No backpressure: a sample is consumed every cycle that update_i or close_i is high.
module min_max_acc #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,      // hold accumulators at their empty values
    input  logic              update_i,     // fold sample_i into the running pair
    input  logic              close_i,      // close the interval with sample_i, then reload
    input  logic              peak_mode_i,  // 1 = min/max of interval, 0 = closing sample only
    input  logic [DATA_W-1:0] sample_i,
    output logic [DATA_W-1:0] res_min_o,
    output logic [DATA_W-1:0] res_max_o
);

    localparam logic [DATA_W-1:0] ACC_MIN_EMPTY = '1;
    localparam logic [DATA_W-1:0] ACC_MAX_EMPTY = '0;

    logic [DATA_W-1:0] acc_min_q;
    logic [DATA_W-1:0] acc_max_q;
    logic [DATA_W-1:0] acc_min_d;
    logic [DATA_W-1:0] acc_max_d;
    logic [DATA_W-1:0] incl_min;
    logic [DATA_W-1:0] incl_max;

    // Running pair including the current sample (unsigned compare).
    always_comb begin
        incl_min = (sample_i < acc_min_q) ? sample_i : acc_min_q;
        incl_max = (sample_i > acc_max_q) ? sample_i : acc_max_q;
    end

    // Interval result: in plain-decimation mode the closing sample stands for both.
    always_comb begin
        res_min_o = peak_mode_i ? incl_min : sample_i;
        res_max_o = peak_mode_i ? incl_max : sample_i;
    end

    // Next accumulator value: a close reloads so the following sample starts a fresh interval.
    always_comb begin
        acc_min_d = acc_min_q;
        acc_max_d = acc_max_q;
        if (clear_i || close_i) begin
            acc_min_d = ACC_MIN_EMPTY;
            acc_max_d = ACC_MAX_EMPTY;
        end else if (update_i) begin
            acc_min_d = incl_min;
            acc_max_d = incl_max;
        end
    end

    // Accumulator registers, empty on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_min_q <= ACC_MIN_EMPTY;
            acc_max_q <= ACC_MAX_EMPTY;
        end else begin
            acc_min_q <= acc_min_d;
            acc_max_q <= acc_max_d;
        end
    end

endmodule : min_max_acc

// File: rtl/min_max_detector.sv
// Decimating min/max peak detector feeding a sample memory with {max, min} words.
// Latency: WR_EN one cycle after the closing CLK_EN; one write per cycle sustained.
// No backpressure: the memory must accept every WR_EN; Start_WR low aborts at once.
module min_max_detector
    import min_max_detector_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                CLK,
    input  logic                nRESET,
    input  logic                Start_WR,
    input  logic                CLK_EN,
    input  logic                Peak_Mode,
    input  logic [DATA_W-1:0]   ADC_Data,
    output logic                WR_EN,
    output logic [ADDR_W-1:0]   WR_Addr,
    output logic [2*DATA_W-1:0] WR_Data,
    output logic                Full
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e              state_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [2*DATA_W-1:0] wr_data_q;
    logic                full_q;

    logic                running;
    logic                last_write;
    logic                close_ok;
    logic [DATA_W-1:0]   res_min;
    logic [DATA_W-1:0]   res_max;

    // Qualifiers: accumulate only while running; the write to the last address
    // ends acquisition, so a close landing on that same edge is dropped.
    always_comb begin
        running    = (state_q == ST_RUN) && Start_WR;
        last_write = wr_en_q && (wr_addr_q == ADDR_LAST);
        close_ok   = running && CLK_EN && !last_write;
    end

    min_max_acc #(
        .DATA_W (DATA_W)
    ) u_acc (
        .clk_i       (CLK),
        .rst_ni      (nRESET),
        .clear_i     (!running),
        .update_i    (running),
        .close_i     (running && CLK_EN),
        .peak_mode_i (Peak_Mode),
        .sample_i    (ADC_Data),
        .res_min_o   (res_min),
        .res_max_o   (res_max)
    );

    // Acquisition FSM with address counter and registered write port.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            full_q    <= 1'b0;
        end else if (!Start_WR) begin
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            full_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q   <= ST_RUN;
                    wr_en_q   <= 1'b0;
                    wr_addr_q <= '0;
                    full_q    <= 1'b0;
                end
                ST_RUN: begin
                    if (last_write) begin
                        state_q <= ST_DONE;
                        full_q  <= 1'b1;
                    end else if (wr_en_q) begin
                        wr_addr_q <= wr_addr_q + ADDR_ONE;
                    end
                    wr_en_q <= close_ok;
                    if (close_ok) begin
                        wr_data_q <= {res_max, res_min};
                    end
                end
                ST_DONE: begin
                    wr_en_q <= 1'b0;
                    full_q  <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    wr_en_q   <= 1'b0;
                    wr_addr_q <= '0;
                    full_q    <= 1'b0;
                end
            endcase
        end
    end

    // The strobe is gated by Start_WR so a write still pending when acquisition
    // is withdrawn never reaches the memory.
    always_comb begin
        WR_EN   = wr_en_q && Start_WR;
        WR_Addr = wr_addr_q;
        WR_Data = wr_data_q;
        Full    = full_q;
    end

endmodule : min_max_detector

// File: tb/tb_min_max_detector.sv
module tb_min_max_detector;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          nRESET;
    logic          Start_WR;
    logic          CLK_EN;
    logic          Peak_Mode;
    logic [DW-1:0] ADC_Data;
    logic          WR_EN;
    logic [AW-1:0] WR_Addr;
    logic [2*DW-1:0] WR_Data;
    logic          Full;

    int total = 0;
    int bad   = 0;

    min_max_detector #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .Start_WR  (Start_WR),
        .CLK_EN    (CLK_EN),
        .Peak_Mode (Peak_Mode),
        .ADC_Data  (ADC_Data),
        .WR_EN     (WR_EN),
        .WR_Addr   (WR_Addr),
        .WR_Data   (WR_Data),
        .Full      (Full)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, then advance one rising edge; outputs are observed 1ns later.
    task automatic tick(input logic s, input logic e, input logic p, input logic [DW-1:0] d);
        Start_WR  = s;
        CLK_EN    = e;
        Peak_Mode = p;
        ADC_Data  = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [AW-1:0] a,
                           input logic [2*DW-1:0] d, input logic f);
        chk({tag, ".en"},   32'(WR_EN),   32'(en));
        chk({tag, ".addr"}, 32'(WR_Addr), 32'(a));
        if (en) chk({tag, ".data"}, 32'(WR_Data), 32'(d));
        chk({tag, ".full"}, 32'(Full),    32'(f));
    endtask

    initial begin
        nRESET = 1'b0; Start_WR = 1'b0; CLK_EN = 1'b0; Peak_Mode = 1'b1; ADC_Data = '0;
        #12;
        chk("rst.en",   32'(WR_EN),   32'd0);
        chk("rst.addr", 32'(WR_Addr), 32'd0);
        chk("rst.data", 32'(WR_Data), 32'd0);
        chk("rst.full", 32'(Full),    32'd0);
        nRESET = 1'b1;

        // Peak mode, interval 10,200,5,90 -> {200,5} at address 0.
        tick(1, 0, 1, 8'd0);               // IDLE -> RUN, sample ignored
        chk_out("pk.enter", 0, 0, 16'h0, 0);
        tick(1, 0, 1, 8'd10);
        tick(1, 0, 1, 8'd200);
        tick(1, 0, 1, 8'd5);
        chk_out("pk.noearly", 0, 0, 16'h0, 0);
        tick(1, 1, 1, 8'd90);
        chk_out("pk.wr", 1, 0, {8'd200, 8'd5}, 0);
        tick(1, 0, 1, 8'd3);
        chk_out("pk.after", 0, 1, 16'h0, 0);

        // Plain mode with same samples; Peak_Mode flips only at the close.
        tick(0, 0, 1, 8'd0);
        chk_out("idle", 0, 0, 16'h0, 0);
        tick(1, 0, 1, 8'd0);
        tick(1, 0, 1, 8'd10);
        tick(1, 0, 1, 8'd200);
        tick(1, 0, 1, 8'd5);
        tick(1, 1, 0, 8'd90);
        chk_out("plain.wr", 1, 0, {8'd90, 8'd90}, 0);
        tick(1, 0, 0, 8'd7);
        tick(1, 0, 0, 8'd3);
        tick(1, 1, 1, 8'd9);
        chk_out("modesw.wr", 1, 1, {8'd9, 8'd3}, 0);

        // Start_WR withdrawn while a write is pending.
        tick(1, 0, 1, 8'd50);
        tick(1, 1, 1, 8'd60);
        chk_out("abort.pend", 1, 2, {8'd60, 8'd50}, 0);
        Start_WR = 1'b0;
        #1;
        chk("abort.suppr", 32'(WR_EN), 32'd0);
        tick(0, 0, 1, 8'd0);
        chk_out("abort.idle", 0, 0, 16'h0, 0);
        tick(1, 0, 1, 8'd0);
        tick(1, 1, 1, 8'd44);
        chk_out("abort.restart", 1, 0, {8'd44, 8'd44}, 0);

        // Decimation 0: ramp fills the whole memory.
        tick(0, 0, 0, 8'd0);
        tick(1, 0, 0, 8'd0);
        for (int n = 0; n < 16; n++) begin
            tick(1, 1, 0, 8'(n));
            chk_out($sformatf("ramp%0d", n), 1, AW'(n), {8'(n), 8'(n)}, 0);
        end
        tick(1, 1, 0, 8'd99);
        chk_out("ramp.full", 0, 15, 16'h0, 1);

        // CLK_EN in DONE and in IDLE is ignored.
        for (int k = 0; k < 3; k++) begin
            tick(1, 1, 1, 8'(k + 1));
            chk_out($sformatf("done%0d", k), 0, 15, 16'h0, 1);
        end
        for (int k = 0; k < 3; k++) begin
            tick(0, 1, 1, 8'(k + 1));
            chk_out($sformatf("idleen%0d", k), 0, 0, 16'h0, 0);
        end

        // Asynchronous reset between edges mid-RUN.
        tick(1, 0, 1, 8'd0);
        tick(1, 0, 1, 8'd20);
        tick(1, 1, 1, 8'd30);
        chk_out("ar.wr0", 1, 0, {8'd30, 8'd20}, 0);
        tick(1, 1, 1, 8'd40);
        chk_out("ar.wr1", 1, 1, {8'd40, 8'd40}, 0);
        CLK_EN = 1'b0;
        #2;
        nRESET = 1'b0;
        #1;
        chk("ar.en",   32'(WR_EN),   32'd0);
        chk("ar.addr", 32'(WR_Addr), 32'd0);
        chk("ar.data", 32'(WR_Data), 32'd0);
        chk("ar.full", 32'(Full),    32'd0);
        #1;
        nRESET = 1'b1;
        tick(1, 0, 1, 8'd0);
        chk_out("ar.rel0", 0, 0, 16'h0, 0);
        tick(1, 0, 1, 8'd1);
        chk_out("ar.rel1", 0, 0, 16'h0, 0);
        tick(1, 1, 1, 8'd2);
        chk_out("ar.wr", 1, 0, {8'd2, 8'd1}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_min_max_detector

// File: doc/min_max_detector.md
MIN_MAX_DETECTOR -- requirements
Module: min_max_detector

Interface
REQ-001 Parameter DATA_W, default 8: ADC sample width.
REQ-002 Parameter ADDR_W, default 10: sample-memory address width, depth 2**ADDR_W.
REQ-003 CLK  input  1  sole clock, rising edge.
REQ-004 nRESET  input  1  asynchronous, active-low reset.
REQ-005 Start_WR  input  1  acquisition enable, same signal that drives the upstream decimation counter.
REQ-006 CLK_EN  input  1  decimation strobe from the upstream decimation counter; closes one interval.
REQ-007 Peak_Mode  input  1  1 = min/max peak detect, 0 = plain decimated sample.
REQ-008 ADC_Data  input  DATA_W  raw ADC sample, valid every CLK.
REQ-009 WR_EN  output  1  one-cycle sample-memory write strobe.
REQ-010 WR_Addr  output  ADDR_W  sample-memory write address.
REQ-011 WR_Data  output  2*DATA_W  packed word {max, min}.
REQ-012 Full  output  1  memory filled, acquisition finished.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE -> RUN on the first CLK with Start_WR=1; RUN -> DONE on the write to address 2**ADDR_W-1; any state -> IDLE on any CLK with Start_WR=0.
REQ-015 In IDLE: acc_min=all-ones, acc_max=0, WR_Addr=0, WR_EN=0, Full=0.
REQ-016 In RUN, every CLK without CLK_EN SHALL update acc_min=min(acc_min,ADC_Data) and acc_max=max(acc_max,ADC_Data), unsigned compare.
REQ-017 In RUN, a CLK with CLK_EN=1 SHALL close the interval and include that cycle's ADC_Data: result_min=min(acc_min,ADC_Data), result_max=max(acc_max,ADC_Data).
REQ-018 On that same CLK, the accumulators SHALL reload to all-ones and 0, so the next interval starts with the following sample.
REQ-019 If Peak_Mode=0, the closing CLK SHALL instead set result_min=result_max=ADC_Data of the CLK_EN cycle.
REQ-020 Latency: WR_EN=1 for exactly one CLK, the cycle after the closing CLK_EN, with WR_Data={result_max,result_min} and WR_Addr at its current value.
REQ-021 WR_Addr SHALL increment by 1 on the CLK after each WR_EN pulse; it never wraps in RUN.
REQ-022 The write to address 2**ADDR_W-1 SHALL set Full=1 on the following CLK and enter DONE.
REQ-023 DONE SHALL hold Full=1 and WR_Addr, ignore CLK_EN and ADC_Data, and keep WR_EN=0.
REQ-024 CLK_EN on consecutive cycles (decimation 0) SHALL produce one write per cycle with no loss.
REQ-025 If Start_WR falls while a write is pending, that write SHALL be suppressed, WR_EN=0 and the block returns to IDLE on the next CLK.
REQ-026 CLK_EN received in IDLE SHALL be ignored.
REQ-027 A change of Peak_Mode in RUN SHALL take effect at the next closing CLK_EN.

Reset
REQ-028 nRESET=0 SHALL asynchronously force IDLE, WR_EN=0, WR_Addr=0, WR_Data=0, Full=0, acc_min=all-ones and acc_max=0.
REQ-029 Release of nRESET SHALL take effect only on a CLK edge; Start_WR already high then enters RUN on that edge.
REQ-030 nRESET asserted mid-RUN SHALL discard any pending write.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding (IDLE=0, RUN=1, DONE=2) and the defaults for DATA_W and ADDR_W.
REQ-032 One sub-module, min_max_acc, SHALL hold the accumulator pair with its compare, load and reload logic; the FSM, address counter and output register stay in the top level.

Verification
REQ-033 Peak_Mode=1, CLK_EN every 4 CLK, ADC_Data 10,200,5,90 -> one WR_EN with WR_Data={200,5}, WR_Addr=0.
REQ-034 Peak_Mode=0, same stimulus -> WR_Data={90,90}.
REQ-035 CLK_EN every CLK, ADDR_W=4, ramp 0..15 -> 16 writes at addresses 0..15 with data {n,n}, then Full=1 and no further WR_EN.
REQ-036 Start_WR dropped the cycle after CLK_EN -> no WR_EN; next cycle WR_Addr=0 and Full=0; restart begins again at address 0.
REQ-037 nRESET pulsed low between CLK edges mid-RUN -> outputs reach reset values immediately, with no WR_EN after release until a new CLK_EN.
REQ-038 CLK_EN pulses in IDLE and in DONE -> no WR_EN and WR_Addr unchanged.
